// File: rtl/ram_loader.sv
// Byte-stream loader for the 256x32 program/data memory: assembles little-endian
// words from a valid/ready byte stream and exposes a ROM-compatible async read port.
module ram_loader #(
    parameter int DEPTH  = 256,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [31:0]       rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // state is kept as a named register so checkers can bind to it directly.
    state_t            state;
    logic [1:0]        byte_idx;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   remaining;
    logic [23:0]       sr;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic              hs;
    logic              unused_rd_addr;

    // Handshake: a byte transfers on a rising edge where rx_valid && rx_ready;
    // rx_valid may drop at any time and rx_ready is high only in LOAD.
    assign hs       = rx_valid && (state == LOAD);
    assign rx_ready = (state == LOAD);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            byte_idx  <= 2'd0;
            ptr       <= '0;
            remaining <= '0;
            sr        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (word_count != '0) begin
                            ptr       <= base_addr;
                            remaining <= (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
                            byte_idx  <= 2'd0;
                            state     <= LOAD;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                LOAD: begin
                    if (hs) begin
                        if (byte_idx == 2'd3) begin
                            ptr       <= ptr + 1'b1;
                            byte_idx  <= 2'd0;
                            remaining <= remaining - 1'b1;
                            if (remaining == (ADDR_W + 1)'(1)) begin
                                state <= DONE;
                            end
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            case (byte_idx)
                                2'd0:    sr[7:0]   <= rx_data;
                                2'd1:    sr[15:8]  <= rx_data;
                                default: sr[23:16] <= rx_data;
                            endcase
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The fourth byte goes straight into the array alongside the three buffered lanes.
    always_ff @(posedge clk) begin
        if (hs && byte_idx == 2'd3) begin
            mem[ptr] <= {rx_data, sr};
        end
    end

    assign rd_data        = mem[rd_addr[ADDR_W-1:0]];
    assign unused_rd_addr = ^rd_addr[31:ADDR_W];

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: byte-stream loads, gaps, wrap, reset abort,
// corner controls and count saturation, checked against an expected-word queue.
module tb_ram_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [8:0]  word_count = '0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] rd_addr = '0;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  stim[$];
    logic [31:0] exp_q[$];
    logic [7:0]  addr_q[$];

    ram_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 20) begin
            tick();
            n++;
        end
        if (!rx_ready) chk("rx_ready_timeout", {31'b0, rx_ready}, 32'd1);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic start_load(input logic [7:0] base, input logic [8:0] cnt);
        base_addr  = base;
        word_count = cnt;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic push_word(input logic [7:0] addr, input logic [31:0] w);
        addr_q.push_back(addr);
        exp_q.push_back(w);
        stim.push_back(w[7:0]);
        stim.push_back(w[15:8]);
        stim.push_back(w[23:16]);
        stim.push_back(w[31:24]);
    endtask

    task automatic run_load(input logic [7:0] base, input logic [8:0] cnt, input bit gap,
                            input string tag);
        int last;
        last = stim.size() - 1;
        start_load(base, cnt);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        chk({tag, "_rx_ready"}, {31'b0, rx_ready}, 32'd1);
        for (int i = 0; i <= last; i++) begin
            if (gap && i > 0) tick();
            send_byte(stim[i]);
            if (i != last) chk({tag, "_done_early"}, {31'b0, done}, 32'd0);
        end
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_done_rx_ready"}, {31'b0, rx_ready}, 32'd0);
        tick();
        chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        chk({tag, "_busy_fall"}, {31'b0, busy}, 32'd0);
        stim.delete();
    endtask

    // scoreboard
    task automatic check_mem(input string tag);
        while (exp_q.size() > 0) begin
            rd_addr = {24'h0, addr_q.pop_front()};
            #1;
            chk({tag, "_mem"}, rd_data, exp_q.pop_front());
        end
    endtask

    task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        rd_addr = addr;
        #1;
        chk(tag, rd_data, exp);
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // basic back-to-back load
        push_word(8'h10, 32'h12345678);
        push_word(8'h11, 32'hDEADBEEF);
        run_load(8'h10, 9'd2, 1'b0, "basic");
        check_mem("basic");

        // same stream with rx_valid gaps
        push_word(8'h30, 32'h12345678);
        push_word(8'h31, 32'hDEADBEEF);
        run_load(8'h30, 9'd2, 1'b1, "gap");
        check_mem("gap");

        // pointer wrap and ignored upper read-address bits
        push_word(8'hFF, 32'h00000001);
        push_word(8'h00, 32'h00000002);
        run_load(8'hFF, 9'd2, 1'b0, "wrap");
        check_mem("wrap");
        read_chk("wrap_upper_bits", 32'h000001FF, 32'h00000001);

        // word_count = 0: immediate done, nothing written
        start_load(8'h10, 9'd0);
        chk("zero_done", {31'b0, done}, 32'd1);
        chk("zero_rx_ready", {31'b0, rx_ready}, 32'd0);
        tick();
        chk("zero_done_pulse", {31'b0, done}, 32'd0);
        chk("zero_busy", {31'b0, busy}, 32'd0);
        chk("zero_rx_ready_after", {31'b0, rx_ready}, 32'd0);
        read_chk("zero_no_write", 32'h10, 32'h12345678);

        // start pulsed mid-load is ignored
        start_load(8'h40, 9'd2);
        send_byte(8'h01);
        send_byte(8'h02);
        base_addr  = 8'h50;
        word_count = 9'd1;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        send_byte(8'h03);
        send_byte(8'h04);
        chk("ctl_done_early", {31'b0, done}, 32'd0);
        chk("ctl_busy", {31'b0, busy}, 32'd1);
        send_byte(8'h05);
        send_byte(8'h06);
        send_byte(8'h07);
        send_byte(8'h08);
        chk("ctl_done", {31'b0, done}, 32'd1);
        tick();
        chk("ctl_done_pulse", {31'b0, done}, 32'd0);
        read_chk("ctl_mem40", 32'h40, 32'h04030201);
        read_chk("ctl_mem41", 32'h41, 32'h08070605);

        // reset mid-load: first word kept, partial word discarded
        push_word(8'h20, 32'h11111111);
        push_word(8'h21, 32'h22222222);
        run_load(8'h20, 9'd2, 1'b0, "pre");
        check_mem("pre");
        start_load(8'h20, 9'd3);
        send_byte(8'h44);
        send_byte(8'h33);
        send_byte(8'h22);
        send_byte(8'h11);
        send_byte(8'h88);
        send_byte(8'h77);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_rx_ready", {31'b0, rx_ready}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("abort_idle", {31'b0, busy}, 32'd0);
        read_chk("abort_mem20", 32'h20, 32'h11223344);
        read_chk("abort_mem21", 32'h21, 32'h22222222);
        push_word(8'h22, 32'h0A0B0C0D);
        run_load(8'h22, 9'd1, 1'b0, "reload");
        check_mem("reload");
        read_chk("reload_mem21", 32'h21, 32'h22222222);

        // word_count above DEPTH saturates to a full 256-word load
        for (int i = 0; i < 256; i++) begin
            push_word(8'(8'h80 + i), {8'(i) ^ 8'h5A, 8'(i), 8'hC3, 8'(i)});
        end
        run_load(8'h80, 9'd300, 1'b0, "sat");
        check_mem("sat");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
